pippo_rst_ctrl: RTL and testbench

Reset sequencer that consumes the watchdog reset requests (core/chip/system) produced by the timer block. It quiesces the core via a drain handshake, asserts the requested reset domains for a fixed hold time, and releases them outermost-first. It also records the reset cause for software, using the same 2-bit encoding as TSR[WRS].

---
 rtl/pippo_rst_ctrl.sv | 98 +++++++++
 tb/tb_pippo_rst_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pippo_rst_ctrl.sv
// pippo_rst_ctrl: drains the core, then asserts and releases sys/chip/core resets outermost-first, recording cause
module pippo_rst_ctrl #(
  parameter int RST_HOLD  = 16,
  parameter int RST_GAP   = 4,
  parameter int DRAIN_TMO = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rqt_core_rst,
  input  logic       rqt_chip_rst,
  input  logic       rqt_sys_rst,
  input  logic       quiesce_ack,
  input  logic       cause_clr,
  output logic       quiesce_req,
  output logic       core_rst,
  output logic       chip_rst,
  output logic       sys_rst,
  output logic [1:0] rst_cause,
  output logic       drain_tmo,
  output logic       rst_done
);
  typedef enum logic [1:0] {IDLE, DRAIN, ASSERT, RELEASE} state_t;
  localparam int M1   = RST_HOLD > RST_GAP ? RST_HOLD : RST_GAP;
  localparam int CMAX = M1 > DRAIN_TMO ? M1 : DRAIN_TMO;
  localparam int CW   = $clog2(CMAX);
  state_t state, nxt;
  logic [1:0] level, nxt_level, req_lvl, cause_d;
  logic [CW-1:0] cnt, nxt_cnt;
  logic escalate, hold_end, gap_end, tmo_end, raise, drop;
  logic q_d, sys_d, chip_d, core_d, tmo_d, done_d;
  assign req_lvl  = rqt_sys_rst ? 2'd3 : rqt_chip_rst ? 2'd2 : rqt_core_rst ? 2'd1 : 2'd0;
  assign escalate = state == ASSERT && req_lvl > level;
  assign hold_end = cnt == CW'(RST_HOLD - 1);
  assign gap_end  = cnt == CW'(RST_GAP - 1);
  assign tmo_end  = cnt == CW'(DRAIN_TMO - 1);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ASSERT;
      level       <= 2'd3;
      cnt         <= '0;
      quiesce_req <= 1'b0;
      sys_rst     <= 1'b1;
      chip_rst    <= 1'b1;
      core_rst    <= 1'b1;
      rst_cause   <= 2'b00;
      drain_tmo   <= 1'b0;
      rst_done    <= 1'b0;
    end else begin
      state       <= nxt;
      level       <= nxt_level;
      cnt         <= nxt_cnt;
      quiesce_req <= q_d;
      sys_rst     <= sys_d;
      chip_rst    <= chip_d;
      core_rst    <= core_d;
      rst_cause   <= cause_d;
      drain_tmo   <= tmo_d;
      rst_done    <= done_d;
    end
  end
  always_comb begin
    nxt       = state;
    nxt_level = level;
    nxt_cnt   = state == IDLE ? '0 : cnt + 1'b1;
    case (state)
      IDLE: begin
        nxt_level = req_lvl;
        nxt       = req_lvl != 2'd0 ? DRAIN : IDLE;
      end
      DRAIN: begin
        nxt_level = req_lvl > level ? req_lvl : level;
        nxt       = quiesce_ack || tmo_end ? ASSERT : DRAIN;
      end
      ASSERT: begin
        nxt_level = escalate ? req_lvl : level;
        nxt_cnt   = escalate ? '0 : nxt_cnt;
        nxt       = !escalate && hold_end ? (level == 2'd1 ? IDLE : RELEASE) : ASSERT;
      end
      default: begin
        nxt_cnt = gap_end ? '0 : nxt_cnt;
        nxt     = gap_end && !chip_rst ? IDLE : RELEASE;
      end
    endcase
    nxt_cnt = nxt != state ? '0 : nxt_cnt;
  end
  // raise sets the full domain mask of the (possibly upgraded) level; drop clears only the outermost high domain
  always_comb begin
    raise   = nxt == ASSERT && (state != ASSERT || escalate);
    drop    = (state == ASSERT && !escalate && hold_end) || (state == RELEASE && gap_end);
    sys_d   = raise ? nxt_level == 2'd3 : sys_rst & ~drop;
    chip_d  = raise ? nxt_level[1] : chip_rst & ~(drop & ~sys_rst);
    core_d  = raise ? 1'b1 : core_rst & ~(drop & ~sys_rst & ~chip_rst);
    cause_d = raise ? nxt_level : cause_clr ? 2'b00 : rst_cause;
    tmo_d   = state == DRAIN && nxt == ASSERT ? !quiesce_ack : cause_clr ? 1'b0 : drain_tmo;
    q_d     = nxt == DRAIN;
    done_d  = state != IDLE && nxt == IDLE;
  end
endmodule

// File: tb/tb_pippo_rst_ctrl.sv
// tb_pippo_rst_ctrl: directed table plus corner sequences for the reset sequencer
module tb_pippo_rst_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rqt_core_rst = 1'b0, rqt_chip_rst = 1'b0, rqt_sys_rst = 1'b0;
  logic quiesce_ack = 1'b0, cause_clr = 1'b0;
  logic quiesce_req, core_rst, chip_rst, sys_rst, drain_tmo, rst_done;
  logic [1:0] rst_cause;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       ack;
    logic       clr;
    int         n;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];
  pippo_rst_ctrl dut (
    .clk(clk), .rst(rst),
    .rqt_core_rst(rqt_core_rst), .rqt_chip_rst(rqt_chip_rst), .rqt_sys_rst(rqt_sys_rst),
    .quiesce_ack(quiesce_ack), .cause_clr(cause_clr),
    .quiesce_req(quiesce_req), .core_rst(core_rst), .chip_rst(chip_rst), .sys_rst(sys_rst),
    .rst_cause(rst_cause), .drain_tmo(drain_tmo), .rst_done(rst_done)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] outs();
    return {quiesce_req, sys_rst, chip_rst, core_rst, rst_cause, drain_tmo, rst_done};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  initial begin
    int n;
    // outputs packed as {q, sys, chip, core, cause[1:0], tmo, done}
    tbl.push_back('{1'b0, 3'b000, 1'b0, 1'b0,  5, 8'b0_111_00_0_0});
    tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 15, 8'b0_111_00_0_0});
    tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0,  4, 8'b0_011_00_0_0});
    tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0,  4, 8'b0_001_00_0_0});
    tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0,  1, 8'b0_000_00_0_1});
    tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0,  2, 8'b0_000_00_0_0});
    tbl.push_back('{1'b1, 3'b001, 1'b1, 1'b0,  1, 8'b1_000_00_0_0});
    tbl.push_back('{1'b1, 3'b000, 1'b1, 1'b0, 16, 8'b0_001_01_0_0});
    tbl.push_back('{1'b1, 3'b000, 1'b1, 1'b0,  1, 8'b0_000_01_0_1});
    tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0,  2, 8'b0_000_01_0_0});
    tbl.push_back('{1'b1, 3'b010, 1'b0, 1'b0,  1, 8'b1_000_01_0_0});
    tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 63, 8'b1_000_01_0_0});
    tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 16, 8'b0_011_10_1_0});
    tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0,  4, 8'b0_001_10_1_0});
    tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0,  1, 8'b0_000_10_1_1});
    tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0,  1, 8'b0_000_10_1_0});
    tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b1,  1, 8'b0_000_00_0_0});
    tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0,  1, 8'b0_000_00_0_0});
    #2;
    foreach (tbl[v]) begin
      for (int c = 0; c < tbl[v].n; c++) begin
        rst = tbl[v].rst;
        {rqt_sys_rst, rqt_chip_rst, rqt_core_rst} = tbl[v].req;
        quiesce_ack = tbl[v].ack;
        cause_clr = tbl[v].clr;
        step();
        chk($sformatf("vec%0d_cyc%0d", v, c), outs(), tbl[v].exp);
      end
    end
    cause_clr = 1'b0;
    // escalation core -> sys at hold_cnt 5
    rqt_core_rst = 1'b1;
    quiesce_ack = 1'b1;
    step();
    rqt_core_rst = 1'b0;
    step();
    chk("esc_core_in", {sys_rst, chip_rst, core_rst}, 8'b001);
    repeat (5) step();
    rqt_sys_rst = 1'b1;
    step();
    rqt_sys_rst = 1'b0;
    chk("esc_rise", {3'b000, sys_rst, chip_rst, core_rst, rst_cause}, 8'b000_111_11);
    n = 1;
    for (int i = 0; i < 40 && sys_rst; i++) begin step(); if (sys_rst) n++; end
    chk("esc_sys_hold", 8'(n), 8'd16);
    n = 1;
    for (int i = 0; i < 40 && chip_rst; i++) begin step(); if (chip_rst) n++; end
    chk("esc_chip_gap", 8'(n), 8'd4);
    n = 1;
    for (int i = 0; i < 40 && core_rst; i++) begin step(); if (core_rst) n++; end
    chk("esc_core_gap", 8'(n), 8'd4);
    chk("esc_done", outs(), 8'b0_000_11_0_1);
    // sustained request gives back-to-back sequences
    step();
    rqt_core_rst = 1'b1;
    for (int i = 0; i < 40 && !rst_done; i++) step();
    chk("sus_done1", {7'b0, rst_done}, 8'd1);
    step();
    chk("sus_requeue", {7'b0, quiesce_req}, 8'd1);
    rqt_core_rst = 1'b0;
    for (int i = 0; i < 40 && !rst_done; i++) step();
    chk("sus_done2", outs(), 8'b0_000_01_0_1);
    cause_clr = 1'b1;
    step();
    cause_clr = 1'b0;
    chk("sus_clr", outs(), 8'b0_000_00_0_0);
    // reset pulled during RELEASE
    rqt_chip_rst = 1'b1;
    step();
    rqt_chip_rst = 1'b0;
    for (int i = 0; i < 60 && !(core_rst && !chip_rst); i++) step();
    chk("mid_in_release", {core_rst, chip_rst, rst_cause}, 8'b10_10);
    rst = 1'b0;
    step();
    chk("mid_reset", outs(), 8'b0_111_00_0_0);
    rst = 1'b1;
    for (int i = 0; i < 40 && !rst_done; i++) step();
    chk("mid_recover", outs(), 8'b0_000_00_0_1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
